// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug run-control path: command codes,
// state encoding and default widths.
package mips_dbg_pkg;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_RUN  = 3'd1;
  localparam logic [2:0] CMD_HALT = 3'd2;
  localparam logic [2:0] CMD_STEP = 3'd3;
  localparam logic [2:0] CMD_DUMP = 3'd4;

  localparam logic [2:0] ST_HALT     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_STEP     = 3'd2;
  localparam logic [2:0] ST_DUMP_CS  = 3'd3;
  localparam logic [2:0] ST_DUMP_GAP = 3'd4;

  localparam int unsigned NB_STEP_DEF = 16;

  // Host commands are only taken while halted or free-running.
  function automatic logic accepts_cmd(input logic [2:0] st);
    return (st == ST_HALT) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/mips_dbg_dump_timer.sv
// Per-stage DUMP watchdog: counts cycles a chip-select is held and ends the
// stage on the slave's done pulse or after TIMEOUT cycles.
module mips_dbg_dump_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  input  logic spi_done,
  output logic done,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  // A done pulse landing on the final cycle still counts as a clean transfer.
  assign done    = run & (spi_done | at_last);
  assign expired = run & ~spi_done & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips_debug_sequencer.sv
// Run-control sequencer: RUN/HALT/STEP-N pipeline gating and ordered SPI
// stage dumps. Optional breakpoint compare under MIPS_DBG_BREAKPOINT_EN.
module mips_debug_sequencer
  import mips_dbg_pkg::*;
#(
  parameter int unsigned NB_BITS  = 32,
  parameter int unsigned NB_STEP  = NB_STEP_DEF,
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  input  logic [2:0]          i_cmd,
  input  logic [NB_STEP-1:0]  i_step_count,
  output logic                o_cmd_ready,
  input  logic                i_prog_end,
  input  logic [NB_BITS-1:0]  i_pc,
  input  logic [NB_BITS-1:0]  i_bp_addr,
  input  logic                i_bp_enb,
  input  logic                i_spi_done,
  output logic                o_debug_enb,
  output logic [N_STAGES-1:0] o_spi_cs,
  output logic                o_halted,
  output logic                o_bp_hit,
  output logic                o_dump_err,
  output logic [NB_BITS-1:0]  o_cycle_cnt
);

  localparam int unsigned SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic [2:0]          state, state_nxt;
  logic [NB_STEP-1:0]  rem, rem_nxt;
  logic [SW-1:0]       stage, stage_nxt;
  logic [N_STAGES-1:0] cs_nxt;
  logic                accept, stop, bp_match;
  logic                tmr_load, tmr_done, tmr_expired;
  logic                bp_set, bp_clr, err_set, err_clr;

`ifdef MIPS_DBG_BREAKPOINT_EN
  assign bp_match = i_bp_enb & o_debug_enb & (i_pc == i_bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{i_pc, i_bp_addr, i_bp_enb};
  assign bp_match  = 1'b0;
`endif

  assign o_cmd_ready = accepts_cmd(state);
  assign o_halted    = (state == ST_HALT);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign stop        = ((state == ST_RUN) || (state == ST_STEP)) & (i_prog_end | bp_match);

  mips_dbg_dump_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .load     (tmr_load),
    .run      (state == ST_DUMP_CS),
    .spi_done (i_spi_done),
    .done     (tmr_done),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    stage_nxt = stage;
    tmr_load  = 1'b0;
    bp_set    = 1'b0;
    bp_clr    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      ST_HALT: begin
        if (accept) begin
          case (i_cmd)
            CMD_RUN: begin
              state_nxt = ST_RUN;
              bp_clr    = 1'b1;
            end
            CMD_STEP: begin
              state_nxt = ST_STEP;
              rem_nxt   = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;
              bp_clr    = 1'b1;
            end
            CMD_DUMP: begin
              state_nxt = ST_DUMP_CS;
              stage_nxt = '0;
              tmr_load  = 1'b1;
              err_clr   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (stop || (accept && i_cmd == CMD_HALT)) state_nxt = ST_HALT;
      end
      ST_STEP: begin
        // rem counts the enabled cycles still owed, including this one.
        if (stop || rem <= NB_STEP'(1)) state_nxt = ST_HALT;
        else                            rem_nxt   = rem - NB_STEP'(1);
      end
      ST_DUMP_CS: begin
        if (tmr_done) begin
          state_nxt = ST_DUMP_GAP;
          err_set   = tmr_expired;
        end
      end
      ST_DUMP_GAP: begin
        if (stage == SW'(N_STAGES - 1)) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_DUMP_CS;
          stage_nxt = stage + SW'(1);
          tmr_load  = 1'b1;
        end
      end
      default: state_nxt = ST_HALT;
    endcase
    if (stop && bp_match) bp_set = 1'b1;
  end

  always_comb begin
    cs_nxt = '1;
    if (state_nxt == ST_DUMP_CS) cs_nxt[stage_nxt] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_HALT;
      rem         <= '0;
      stage       <= '0;
      o_debug_enb <= 1'b0;
      o_spi_cs    <= '1;
      o_bp_hit    <= 1'b0;
      o_dump_err  <= 1'b0;
      o_cycle_cnt <= '0;
    end else begin
      state       <= state_nxt;
      rem         <= rem_nxt;
      stage       <= stage_nxt;
      o_debug_enb <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      o_spi_cs    <= cs_nxt;
      o_cycle_cnt <= o_cycle_cnt + NB_BITS'(o_debug_enb);
      if (bp_set)      o_bp_hit <= 1'b1;
      else if (bp_clr) o_bp_hit <= 1'b0;
      if (err_set)      o_dump_err <= 1'b1;
      else if (err_clr) o_dump_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Directed bench for mips_debug_sequencer: table-driven run/step vectors plus
// hand sequences for breakpoint, DUMP, timeout, async reset and counter wrap.
module tb_mips_debug_sequencer;
  import mips_dbg_pkg::*;

  localparam int unsigned NB_BITS  = 8;
  localparam int unsigned NB_STEP  = 16;
  localparam int unsigned N_STAGES = 4;
  localparam int unsigned TIMEOUT  = 1024;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [2:0]         cmd = CMD_NOP;
  logic [NB_STEP-1:0] step_count = '0;
  logic               cmd_ready;
  logic               prog_end = 1'b0;
  logic [NB_BITS-1:0] pc = '0;
  logic [NB_BITS-1:0] bp_addr = '0;
  logic               bp_enb = 1'b0;
  logic               spi_done = 1'b0;
  logic               debug_enb;
  logic [3:0]         spi_cs;
  logic               halted, bp_hit, dump_err;
  logic [NB_BITS-1:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_debug_sequencer #(
    .NB_BITS  (NB_BITS),
    .NB_STEP  (NB_STEP),
    .N_STAGES (N_STAGES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .i_step_count (step_count),
    .o_cmd_ready  (cmd_ready),
    .i_prog_end   (prog_end),
    .i_pc         (pc),
    .i_bp_addr    (bp_addr),
    .i_bp_enb     (bp_enb),
    .i_spi_done   (spi_done),
    .o_debug_enb  (debug_enb),
    .o_spi_cs     (spi_cs),
    .o_halted     (halted),
    .o_bp_hit     (bp_hit),
    .o_dump_err   (dump_err),
    .o_cycle_cnt  (cycle_cnt)
  );

  typedef struct {
    logic        v;
    logic [2:0]  c;
    logic [15:0] sc;
    logic        pe;
    logic        enb;
    logic        rdy;
    logic        hlt;
    logic [7:0]  cc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] c, input logic [15:0] sc);
    cmd_valid = 1'b1;
    cmd = c;
    step_count = sc;
    cyc();
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  initial begin
    logic [3:0] exp_cs;
    int         n, halted_at;

    // RUN for 10 cycles then HALT
    tbl.push_back('{1'b1, CMD_RUN,  16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    for (int i = 1; i <= 9; i++)
      tbl.push_back('{1'b0, CMD_NOP, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(i)});
    tbl.push_back('{1'b1, CMD_HALT, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10});
    // STEP 3 (HALT during step must be refused), then STEP 0 acts as 1
    tbl.push_back('{1'b1, CMD_STEP, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10});
    tbl.push_back('{1'b1, CMD_HALT, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd11});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd12});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd13});
    tbl.push_back('{1'b1, CMD_STEP, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd13});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14});
    // prog_end together with HALT, prog_end while halted, prog_end mid-STEP
    tbl.push_back('{1'b1, CMD_RUN,  16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd14});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd15});
    tbl.push_back('{1'b1, CMD_HALT, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd16});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd16});
    tbl.push_back('{1'b1, CMD_STEP, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd16});
    tbl.push_back('{1'b0, CMD_NOP,  16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd17});
    // RUN ignores RUN/STEP/DUMP; undefined opcode and invalid strobe are NOPs
    tbl.push_back('{1'b1, CMD_RUN,  16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd17});
    tbl.push_back('{1'b1, CMD_STEP, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd18});
    tbl.push_back('{1'b1, CMD_DUMP, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd19});
    tbl.push_back('{1'b1, CMD_HALT, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{1'b1, 3'd7,     16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd20});
    tbl.push_back('{1'b0, CMD_RUN,  16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd20});

    repeat (3) @(negedge clk);
    chk("rst_enb", 64'(debug_enb), 64'd0);
    chk("rst_cs", 64'(spi_cs), 64'hF);
    chk("rst_halted", 64'(halted), 64'd1);
    rst_n = 1'b1;
    cyc();
    chk("init_ready", 64'(cmd_ready), 64'd1);
    chk("init_bp", 64'(bp_hit), 64'd0);
    chk("init_err", 64'(dump_err), 64'd0);
    chk("init_cnt", 64'(cycle_cnt), 64'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].v;
      cmd = tbl[i].c;
      step_count = tbl[i].sc;
      prog_end = tbl[i].pe;
      cyc();
      chk($sformatf("v%0d_enb", i), 64'(debug_enb), 64'(tbl[i].enb));
      chk($sformatf("v%0d_ready", i), 64'(cmd_ready), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(tbl[i].hlt));
      chk($sformatf("v%0d_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cc));
      chk($sformatf("v%0d_cs", i), 64'(spi_cs), 64'hF);
    end
    cmd_valid = 1'b0;
    cmd = CMD_NOP;
    prog_end = 1'b0;

    // Breakpoint at 0x20 with PC advancing by 4 per enabled cycle
    bp_addr = 8'h20;
    bp_enb = 1'b1;
    pc = '0;
    send(CMD_RUN, 16'd0);
    halted_at = -1;
    for (int i = 0; i < 12; i++) begin
      pc = 8'(i * 4);
      cyc();
      if (halted && halted_at < 0) halted_at = i;
    end
`ifdef MIPS_DBG_BREAKPOINT_EN
    chk("bp_halt_index", 64'(halted_at), 64'(8));
    chk("bp_hit_set", 64'(bp_hit), 64'd1);
`else
    chk("bp_halt_index", 64'(halted_at), 64'(-1));
    chk("bp_hit_tied", 64'(bp_hit), 64'd0);
    send(CMD_HALT, 16'd0);
`endif
    pc = '0;
    send(CMD_RUN, 16'd0);
    chk("bp_hit_clr", 64'(bp_hit), 64'd0);
    send(CMD_HALT, 16'd0);
    bp_enb = 1'b0;
    chk("bp_halted", 64'(halted), 64'd1);

    // DUMP, every stage answered with a done pulse
    send(CMD_DUMP, 16'd0);
    for (int k = 0; k < 4; k++) begin
      exp_cs = ~(4'b0001 << k);
      chk($sformatf("dump_cs%0d", k), 64'(spi_cs), 64'(exp_cs));
      chk($sformatf("dump_enb%0d", k), 64'(debug_enb), 64'd0);
      chk($sformatf("dump_ready%0d", k), 64'(cmd_ready), 64'd0);
      repeat (4) cyc();
      chk($sformatf("dump_hold%0d", k), 64'(spi_cs), 64'(exp_cs));
      spi_done = 1'b1;
      cyc();
      spi_done = 1'b0;
      chk($sformatf("dump_gap%0d", k), 64'(spi_cs), 64'hF);
      cyc();
    end
    chk("dump_end_halted", 64'(halted), 64'd1);
    chk("dump_end_cs", 64'(spi_cs), 64'hF);
    chk("dump_end_err", 64'(dump_err), 64'd0);

    // DUMP with stage 2 never answering
    send(CMD_DUMP, 16'd0);
    for (int k = 0; k < 2; k++) begin
      repeat (2) cyc();
      spi_done = 1'b1;
      cyc();
      spi_done = 1'b0;
      cyc();
    end
    chk("to_cs2", 64'(spi_cs), 64'hB);
    n = 0;
    while (spi_cs == 4'hB && n < 2 * TIMEOUT) begin
      n++;
      cyc();
    end
    chk("to_cycles", 64'(n), 64'(TIMEOUT));
    chk("to_err", 64'(dump_err), 64'd1);
    chk("to_gap", 64'(spi_cs), 64'hF);
    cyc();
    chk("to_cs3", 64'(spi_cs), 64'h7);
    chk("to_err_hold", 64'(dump_err), 64'd1);

    // Asynchronous reset while stage 3 is selected
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", 64'(spi_cs), 64'hF);
    chk("arst_halted", 64'(halted), 64'd1);
    chk("arst_err", 64'(dump_err), 64'd0);
    chk("arst_cnt", 64'(cycle_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Cycle counter wrap at 2^NB_BITS
    send(CMD_RUN, 16'd0);
    repeat (255) cyc();
    chk("wrap_max", 64'(cycle_cnt), 64'hFF);
    cyc();
    chk("wrap_zero", 64'(cycle_cnt), 64'd0);
    send(CMD_HALT, 16'd0);
    chk("wrap_halted", 64'(halted), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
